// File: rtl/bus_slave_wait_ram_pkg.sv
// Shared definitions for the wait-state RAM slave.
// Covers the bus direction and strobe polarities, the data word width, the
// wait counter width and the 2-bit FSM state encoding.
package bus_slave_wait_ram_pkg;
  localparam logic READ     = 1'b1;
  localparam logic WRITE    = 1'b0;
  localparam logic ENABLE_  = 1'b0;  // active-low asserted level
  localparam logic DISABLE_ = 1'b1;

  localparam int WORD_DATA_W = 32;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_e;
endpackage

// File: rtl/bus_slave_wait_ram_if.sv
// Bus slice seen by one slave.
// Request side : cs_n, as_n, rw, addr, wr_data (driven by the master).
// Response side: rd_data, rdy_n (driven by the slave).
interface bus_slave_wait_ram_if #(parameter int ADDR_W = 8);
  import bus_slave_wait_ram_pkg::*;

  logic                   cs_n;
  logic                   as_n;
  logic                   rw;
  logic [ADDR_W-1:0]      addr;
  logic [WORD_DATA_W-1:0] wr_data;
  logic [WORD_DATA_W-1:0] rd_data;
  logic                   rdy_n;

  modport master (output cs_n, as_n, rw, addr, wr_data, input rd_data, rdy_n);
  modport slave  (input cs_n, as_n, rw, addr, wr_data, output rd_data, rdy_n);
endinterface

// File: rtl/bus_slave_ram_core.sv
// Word RAM, 2^ADDR_W x DATA_W, with no reset.
// Synchronous write on clk rising edge when we=1; asynchronous read.
// Ports: clk, we, wr_addr, wr_data, rd_addr, rd_data.
module bus_slave_ram_core #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk)
    if (we) mem[wr_addr] <= wr_data;

  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/bus_slave_wait_ram.sv
// Bus slave with scratchpad RAM and WAIT_CYCLES programmable wait states.
// Ports:
//   clk   - clock, rising edge
//   reset - asynchronous active-low reset
//   bus   - slave modport: cs_n/as_n/rw/addr/wr_data in, rd_data/rdy_n out
// rdy_n pulses low for one cycle per completed access. rd_data is nonzero
// only during that pulse, and only for reads, so it can be OR-combined.
module bus_slave_wait_ram
  import bus_slave_wait_ram_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  bus_slave_wait_ram_if.slave   bus
);
  state_e                 state;
  logic [CNT_W-1:0]       cnt;
  logic [ADDR_W-1:0]      addr_q;
  logic                   rw_q;
  logic [WORD_DATA_W-1:0] wr_data_q;
  logic                   rdy_n_q;
  logic [WORD_DATA_W-1:0] rd_data_q;

  logic [ADDR_W-1:0]      rd_addr;
  logic [WORD_DATA_W-1:0] ram_rd;
  logic                   we;
  logic                   req;

  assign req = (bus.cs_n == ENABLE_) && (bus.as_n == ENABLE_);

  // With zero wait states, ACK is entered on the accepting edge, before
  // addr_q holds the address, so the RAM is read at the live bus address.
  assign rd_addr = (state == ST_IDLE) ? bus.addr : addr_q;

  // The write commits on the edge leaving ACK. Reset forces the state to
  // IDLE asynchronously, which drops we and discards a pending write.
  assign we = (state == ST_ACK) && (rw_q == WRITE);

  bus_slave_ram_core #(.ADDR_W(ADDR_W), .DATA_W(WORD_DATA_W)) u_ram (
    .clk     (clk),
    .we      (we),
    .wr_addr (addr_q),
    .wr_data (wr_data_q),
    .rd_addr (rd_addr),
    .rd_data (ram_rd)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      rw_q      <= READ;
      wr_data_q <= '0;
      rdy_n_q   <= DISABLE_;
      rd_data_q <= '0;
    end else begin
      rdy_n_q   <= DISABLE_;
      rd_data_q <= '0;
      case (state)
        ST_IDLE: if (req) begin
          addr_q    <= bus.addr;
          rw_q      <= bus.rw;
          wr_data_q <= bus.wr_data;
          if (WAIT_CYCLES == 0) begin
            state     <= ST_ACK;
            rdy_n_q   <= ENABLE_;
            rd_data_q <= (bus.rw == READ) ? ram_rd : '0;
          end else begin
            cnt   <= CNT_W'(WAIT_CYCLES - 1);
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!req) begin
            // The master withdrew the request, so abort without a write or a ready pulse.
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (cnt == '0) begin
            state     <= ST_ACK;
            rdy_n_q   <= ENABLE_;
            rd_data_q <= (rw_q == READ) ? ram_rd : '0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_ACK:  state <= ST_IDLE;  // request is not re-sampled here
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.rdy_n   = rdy_n_q;
  assign bus.rd_data = rd_data_q;
endmodule

// File: tb/tb_bus_slave_wait_ram.sv
module tb_bus_slave_wait_ram;
  localparam int N = 5;  // dut0:W=1 dut1:W=0 dut2:W=3 dut3:W=2 dut4:W=15

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cs_n [N];
  logic        as_n [N];
  logic        rw   [N];
  logic [7:0]  addr [N];
  logic [31:0] wd   [N];
  logic [31:0] rdd  [N];
  logic        rdy  [N];

  int ncmp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : u
    localparam int W = (g == 0) ? 1 : (g == 1) ? 0 : (g == 2) ? 3 : (g == 3) ? 2 : 15;
    bus_slave_wait_ram_if #(.ADDR_W(8)) bus ();
    assign bus.cs_n    = cs_n[g];
    assign bus.as_n    = as_n[g];
    assign bus.rw      = rw[g];
    assign bus.addr    = addr[g];
    assign bus.wr_data = wd[g];
    assign rdd[g]      = bus.rd_data;
    assign rdy[g]      = bus.rdy_n;
    bus_slave_wait_ram #(.ADDR_W(8), .WAIT_CYCLES(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
    );
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_bus(input int i);
    cs_n[i] = 1'b1; as_n[i] = 1'b1; rw[i] = 1'b1; addr[i] = 8'h00; wd[i] = 32'h0;
  endtask

  // Single access: assert at a negedge, hold until rdy_n is seen low at a
  // negedge, then release. lat counts negedges up to the ready one.
  task automatic access(input int i, input logic r, input logic [7:0] a, input logic [31:0] d,
                        output logic [31:0] got, output int lat, output bit quiet);
    cs_n[i] = 1'b0; as_n[i] = 1'b0; rw[i] = r; addr[i] = a; wd[i] = d;
    got = 32'hFFFF_FFFF; lat = 99; quiet = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (rdy[i] === 1'b0) begin got = rdd[i]; lat = n; break; end
      if (rdd[i] !== 32'h0) quiet = 1'b0;
    end
    idle_bus(i);
  endtask

  typedef struct {
    int          idx;
    logic        rw;
    logic [7:0]  addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    int          exp_lat;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [31:0] got;
    int          lat;
    bit          quiet;
    for (int i = 0; i < N; i++) idle_bus(i);

    vecs[0] = '{0, 1'b0, 8'h05, 32'hDEADBEEF, 32'h0,        2};
    vecs[1] = '{0, 1'b1, 8'h05, 32'h0,        32'hDEADBEEF, 2};
    vecs[2] = '{1, 1'b0, 8'h00, 32'h11,       32'h0,        1};
    vecs[3] = '{1, 1'b0, 8'h01, 32'h22,       32'h0,        1};
    vecs[4] = '{1, 1'b0, 8'h02, 32'h33,       32'h0,        1};
    vecs[5] = '{1, 1'b0, 8'h03, 32'h44,       32'h0,        1};
    vecs[6] = '{2, 1'b0, 8'h10, 32'hCAFEF00D, 32'h0,        4};
    vecs[7] = '{3, 1'b0, 8'h20, 32'hA5A5A5A5, 32'h0,        3};
    vecs[8] = '{4, 1'b0, 8'h30, 32'h0BADF00D, 32'h0,        16};
    vecs[9] = '{4, 1'b0, 8'h31, 32'h13579BDF, 32'h0,        16};

    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("rst_rdy%0d", i), {31'b0, rdy[i]}, 32'h1);
      chk($sformatf("rst_rd%0d", i), rdd[i], 32'h0);
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("post_rst_rdy%0d", i), {31'b0, rdy[i]}, 32'h1);
      chk($sformatf("post_rst_rd%0d", i), rdd[i], 32'h0);
    end

    // Table-driven single accesses
    for (int v = 0; v < 10; v++) begin
      access(vecs[v].idx, vecs[v].rw, vecs[v].addr, vecs[v].wd, got, lat, quiet);
      chk($sformatf("vec%0d_lat", v), lat, vecs[v].exp_lat);
      chk($sformatf("vec%0d_rd", v), got, vecs[v].exp_rd);
      chk($sformatf("vec%0d_quiet", v), {31'b0, quiet}, 32'h1);
      @(negedge clk);
      chk($sformatf("vec%0d_rdy_after", v), {31'b0, rdy[vecs[v].idx]}, 32'h1);
      chk($sformatf("vec%0d_rd_after", v), rdd[vecs[v].idx], 32'h0);
    end

    // W=0 back-to-back reads with as_n held low throughout
    cs_n[1] = 1'b0; as_n[1] = 1'b0; rw[1] = 1'b1; addr[1] = 8'h00;
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      chk($sformatf("b2b_rdy%0d", j), {31'b0, rdy[1]}, (j % 2 == 1) ? 32'h0 : 32'h1);
      if (j % 2 == 1) begin
        chk($sformatf("b2b_data%0d", j), rdd[1], 32'h11 * ((j + 1) / 2));
        addr[1] = 8'((j + 1) / 2);
      end
      if (j == 8) idle_bus(1);
    end

    // W=3 write aborted after two cycles
    cs_n[2] = 1'b0; as_n[2] = 1'b0; rw[2] = 1'b0; addr[2] = 8'h10; wd[2] = 32'h12345678;
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      chk($sformatf("abort_rdy%0d", j), {31'b0, rdy[2]}, 32'h1);
      if (j == 2) idle_bus(2);
    end
    access(2, 1'b1, 8'h10, 32'h0, got, lat, quiet);
    chk("abort_read_lat", lat, 4);
    chk("abort_read_data", got, 32'hCAFEF00D);

    // Chip select inactive with strobe active
    cs_n[0] = 1'b1; as_n[0] = 1'b0; rw[0] = 1'b0; addr[0] = 8'h05; wd[0] = 32'h0;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      chk($sformatf("nocs_rdy%0d", j), {31'b0, rdy[0]}, 32'h1);
    end
    idle_bus(0);
    access(0, 1'b1, 8'h05, 32'h0, got, lat, quiet);
    chk("nocs_lat", lat, 2);
    chk("nocs_data", got, 32'hDEADBEEF);

    // W=2 reset asserted during WAIT of a write
    cs_n[3] = 1'b0; as_n[3] = 1'b0; rw[3] = 1'b0; addr[3] = 8'h20; wd[3] = 32'h5555AAAA;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_wait_rdy", {31'b0, rdy[3]}, 32'h1);
    chk("rst_wait_rd", rdd[3], 32'h0);
    idle_bus(3);
    @(negedge clk);
    reset = 1'b1;
    access(3, 1'b1, 8'h20, 32'h0, got, lat, quiet);
    chk("rst_wait_lat", lat, 3);
    chk("rst_wait_data", got, 32'hA5A5A5A5);

    // W=1 reset asserted during ACK of a read: outputs drop at once
    cs_n[0] = 1'b0; as_n[0] = 1'b0; rw[0] = 1'b1; addr[0] = 8'h05;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ack_pre_rdy", {31'b0, rdy[0]}, 32'h0);
    reset = 1'b0;
    #1;
    chk("rst_ack_rdy", {31'b0, rdy[0]}, 32'h1);
    chk("rst_ack_rd", rdd[0], 32'h0);
    idle_bus(0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // W=15 read with addr/rw toggling during WAIT
    cs_n[4] = 1'b0; as_n[4] = 1'b0; rw[4] = 1'b1; addr[4] = 8'h30; wd[4] = 32'hFFFF0000;
    got = 32'hFFFF_FFFF; lat = 99;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (rdy[4] === 1'b0) begin got = rdd[4]; lat = n; break; end
      addr[4] = (addr[4] == 8'h30) ? 8'h31 : 8'h30;
      rw[4]   = ~rw[4];
    end
    idle_bus(4);
    chk("toggle_lat", lat, 16);
    chk("toggle_data", got, 32'h0BADF00D);
    @(negedge clk);
    access(4, 1'b1, 8'h31, 32'h0, got, lat, quiet);
    chk("toggle_nowrite", got, 32'h13579BDF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
